// File: rtl/fetch_stage.sv
// Instruction fetch: owns the word PC, drives a sync-read imem port, and fills the Decode slot after a 1-cycle latency.
// A stall freezes the slot using a captured copy of the instruction. A taken branch redirects the PC and emits one bubble.
module fetch_stage #(
    parameter int               PC_W      = 32,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [31:0]     instr_d,
    output logic [PC_W-1:0] pc_d,
    output logic            valid_d,
    output logic [31:0]     fetch_count
);

    logic [PC_W-1:0] pc_f_q,        pc_f_d;
    logic [PC_W-1:0] pc_d_q,        pc_d_d;
    logic            valid_d_q,     valid_d_d;
    logic            hold_q,        hold_d;
    logic [31:0]     instr_hold_q,  instr_hold_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    // The memory registers imem_addr on every edge, so it must already read RESET_PC while rst is high.
    assign imem_addr   = rst ? RESET_PC : pc_f_q;
    assign pc_d        = pc_d_q;
    assign valid_d     = valid_d_q;
    assign fetch_count = fetch_count_q;

    always_comb begin
        instr_d = imem_rdata;
        if (!valid_d_q) begin
            instr_d = NOP_INSTR;
        end else if (hold_q) begin
            instr_d = instr_hold_q;
        end
    end

    always_comb begin
        pc_f_d        = pc_f_q;
        pc_d_d        = pc_d_q;
        valid_d_d     = valid_d_q;
        hold_d        = hold_q;
        instr_hold_d  = instr_hold_q;
        fetch_count_d = fetch_count_q;

        if (branch_taken) begin
            pc_f_d    = branch_target;
            valid_d_d = 1'b0;
            hold_d    = 1'b0;
        end else if (stall) begin
            // Capture only on the first stall cycle; imem_rdata moves on after that edge.
            if (!hold_q) begin
                instr_hold_d = instr_d;
                hold_d       = 1'b1;
            end
        end else begin
            pc_d_d    = pc_f_q;
            pc_f_d    = pc_f_q + PC_W'(1);
            valid_d_d = 1'b1;
            hold_d    = 1'b0;
        end

        if (valid_d_q && !stall && !branch_taken) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q        <= RESET_PC;
            pc_d_q        <= '0;
            valid_d_q     <= 1'b0;
            hold_q        <= 1'b0;
            instr_hold_q  <= NOP_INSTR;
            fetch_count_q <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            pc_d_q        <= pc_d_d;
            valid_d_q     <= valid_d_d;
            hold_q        <= hold_d;
            instr_hold_q  <= instr_hold_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 32-bit PC instance and a 4-bit PC instance (wrap case), each with a sync-read memory model.
module tb_fetch_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic [31:0] addr;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst_m = 1'b1, stall_m = 1'b0, br_m = 1'b0;
    logic [31:0] tgt_m = '0, addr_m, rdata_m, instr_m, pc_m, cnt_m;
    logic        valid_m;

    // Narrow-PC instance
    logic        rst_s = 1'b1, stall_s = 1'b0, br_s = 1'b0;
    logic [3:0]  tgt_s = '0, addr_s, pc_s;
    logic [31:0] rdata_s, instr_s, cnt_s;
    logic        valid_s;

    exp_t q_m[$];
    exp_t q_s[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] memw(input int i);
        case (i)
            0:       return 32'h0080_0199;
            1:       return 32'hC000_0200;
            2:       return 32'h0C90_0000;
            3:       return 32'hC000_0330;
            default: return 32'hA000_0000 | 32'(i);
        endcase
    endfunction

    always @(posedge clk) rdata_m <= memw(int'(addr_m[7:0]));
    always @(posedge clk) rdata_s <= memw(int'(addr_s));

    fetch_stage #(.PC_W(32), .RESET_PC(32'd0), .NOP_INSTR(NOP)) dut_m (
        .clk(clk), .rst(rst_m), .imem_addr(addr_m), .imem_rdata(rdata_m),
        .stall(stall_m), .branch_taken(br_m), .branch_target(tgt_m),
        .instr_d(instr_m), .pc_d(pc_m), .valid_d(valid_m), .fetch_count(cnt_m)
    );

    fetch_stage #(.PC_W(4), .RESET_PC(4'd0), .NOP_INSTR(NOP)) dut_s (
        .clk(clk), .rst(rst_s), .imem_addr(addr_s), .imem_rdata(rdata_s),
        .stall(stall_s), .branch_taken(br_s), .branch_target(tgt_s),
        .instr_d(instr_s), .pc_d(pc_s), .valid_d(valid_s), .fetch_count(cnt_s)
    );

    task automatic compare(input string name, input int idx, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got v=%0b pc=%0d instr=%h cnt=%0d addr=%0d, want v=%0b pc=%0d instr=%h cnt=%0d addr=%0d",
                     name, idx, act.v, act.pc, act.instr, act.cnt, act.addr,
                     exp.v, exp.pc, exp.instr, exp.cnt, exp.addr);
        end
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge.
    int n_m = 0;
    int n_s = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_m.size() > 0) begin
                compare("main", n_m, '{valid_m, pc_m, instr_m, cnt_m, addr_m}, q_m.pop_front());
                n_m++;
            end
            if (q_s.size() > 0) begin
                compare("narrow", n_s, '{valid_s, {28'd0, pc_s}, instr_s, cnt_s, {28'd0, addr_s}}, q_s.pop_front());
                n_s++;
            end
        end
    end

    task automatic step_m(input logic r, input logic s, input logic b, input logic [31:0] t,
                          input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] cnt, input logic [31:0] addr);
        @(negedge clk);
        rst_m = r; stall_m = s; br_m = b; tgt_m = t;
        q_m.push_back('{v, pc, ins, cnt, addr});
    endtask

    task automatic step_s(input logic r, input logic b, input logic [3:0] t,
                          input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] cnt, input logic [31:0] addr);
        @(negedge clk);
        rst_s = r; stall_s = 1'b0; br_s = b; tgt_s = t;
        q_s.push_back('{v, pc, ins, cnt, addr});
    endtask

    // Narrow PC: branch to 15 must wrap to 0 then 1.
    initial begin
        step_s(1, 0, 0,  0, 0,  NOP,           0, 0);
        step_s(0, 0, 0,  1, 0,  32'h0080_0199, 0, 1);
        step_s(0, 1, 15, 0, 0,  NOP,           0, 15);
        step_s(0, 0, 0,  1, 15, 32'hA000_000F, 0, 0);
        step_s(0, 0, 0,  1, 0,  32'h0080_0199, 1, 1);
        step_s(0, 0, 0,  1, 1,  32'hC000_0200, 2, 2);
        @(negedge clk);
        rst_s = 1'b0; br_s = 1'b0;
    end

    initial begin
        // Reset then stream mem[0..3]
        step_m(1, 0, 0, 0,   0, 0,  NOP,           0, 0);
        step_m(1, 0, 0, 0,   0, 0,  NOP,           0, 0);
        step_m(0, 0, 0, 0,   1, 0,  32'h0080_0199, 0, 1);
        step_m(0, 0, 0, 0,   1, 1,  32'hC000_0200, 1, 2);
        step_m(0, 0, 0, 0,   1, 2,  32'h0C90_0000, 2, 3);
        step_m(0, 0, 0, 0,   1, 3,  32'hC000_0330, 3, 4);
        // Back to pc 1, then branch to 16 from pc_d=1
        step_m(0, 0, 1, 1,   0, 3,  NOP,           3, 1);
        step_m(0, 0, 0, 0,   1, 1,  32'hC000_0200, 3, 2);
        step_m(0, 0, 1, 16,  0, 1,  NOP,           3, 16);
        step_m(0, 0, 0, 0,   1, 16, 32'hA000_0010, 3, 17);
        step_m(0, 0, 0, 0,   1, 17, 32'hA000_0011, 4, 18);
        // Reach pc_d=2, stall 3 cycles, release
        step_m(0, 0, 1, 2,   0, 17, NOP,           4, 2);
        step_m(0, 0, 0, 0,   1, 2,  32'h0C90_0000, 4, 3);
        for (int i = 0; i < 3; i++)
            step_m(0, 1, 0, 0, 1, 2, 32'h0C90_0000, 4, 3);
        step_m(0, 0, 0, 0,   1, 3,  32'hC000_0330, 5, 4);
        step_m(0, 0, 0, 0,   1, 4,  32'hA000_0004, 6, 5);
        // Stall and branch together: branch wins, no count
        step_m(0, 1, 1, 25,  0, 4,  NOP,           6, 25);
        step_m(0, 0, 0, 0,   1, 25, 32'hA000_0019, 6, 26);
        step_m(0, 0, 0, 0,   1, 26, 32'hA000_001A, 7, 27);
        // Stall during a bubble keeps the bubble
        step_m(0, 0, 1, 5,   0, 26, NOP,           7, 5);
        step_m(0, 1, 0, 0,   0, 26, NOP,           7, 5);
        step_m(0, 0, 0, 0,   1, 5,  32'hA000_0005, 7, 6);
        // Reset mid-stall
        step_m(0, 1, 0, 0,   1, 5,  32'hA000_0005, 7, 6);
        step_m(1, 1, 0, 0,   0, 0,  NOP,           0, 0);
        step_m(0, 0, 0, 0,   1, 0,  32'h0080_0199, 0, 1);
        @(negedge clk);
        stall_m = 1'b0; br_m = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_m.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL drain: pending main=%0d narrow=%0d, want 0 0", q_m.size(), q_s.size());
        end
        checks++;
        if (n_m != 27 || n_s != 6) begin
            errors++;
            $display("FAIL count: compared main=%0d narrow=%0d, want 27 6", n_m, n_s);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the single-issue ARM-style pipeline; it produces the `instr`/`pc` pair consumed by `Decode`. It owns the word-addressed program counter and drives a synchronous-read instruction memory port. It holds the decode slot on a downstream stall and redirects on a taken branch resolved later in the pipeline. A retired-fetch counter is included for bring-up and performance checks.

## Interface
- `PC_W`, 32: PC and address width. Word addresses; PC steps by 1.
- `RESET_PC`, 0: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0000: instruction word driven to Decode when the slot is invalid.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out PC_W: fetch address, combinational copy of the internal `pc_f`.
- `imem_rdata` in 32: memory word. Synchronous read, so the value in cycle n+1 is `mem[imem_addr sampled at edge n]`.
- `stall` in 1: hold the decode slot and the fetch PC.
- `branch_taken` in 1: redirect the fetch PC.
- `branch_target` in PC_W: redirect word address.
- `instr_d` out 32: instruction presented to Decode.
- `pc_d` out PC_W: address of `instr_d`.
- `valid_d` out 1: the slot holds a real instruction. Downstream gates `RegWrite`/`MemWrite`/`FlagW` with it.
- `fetch_count` out 32: number of instructions accepted by Decode.

## Operation
- State: `pc_f`, `pc_d`, `valid_d`, `hold`, `instr_hold`, `fetch_count`.
- `instr_d` = `NOP_INSTR` if `!valid_d`; else `instr_hold` if `hold`; else `imem_rdata`.
- Priority per edge: `rst` > `branch_taken` > `stall` > normal.
- Reset:
  - `pc_f`=RESET_PC, `pc_d`=0, `valid_d`=0, `hold`=0, `instr_hold`=NOP_INSTR, `fetch_count`=0.
  - `imem_addr`=RESET_PC throughout reset.
- Normal (no stall, no branch):
  - `pc_d`<=`pc_f`, `pc_f`<=`pc_f`+1 (wraps mod 2^PC_W), `valid_d`<=1, `hold`<=0.
- Stall (no branch):
  - `pc_f`, `pc_d`, `valid_d` hold.
  - If `hold`=0: `instr_hold`<=current `instr_d`, `hold`<=1. If already `hold`=1: unchanged.
  - `imem_addr` stays `pc_f`. On the release edge the memory samples it, so the next slot is correct without refetch.
- Branch taken (regardless of stall):
  - `pc_f`<=`branch_target`, `valid_d`<=0, `hold`<=0, `pc_d` holds.
  - The instruction currently in the slot is dropped.
- `fetch_count` increments by 1 (wrapping) on every edge with `valid_d`=1, `stall`=0, `branch_taken`=0, `rst`=0.
- A stall with `valid_d`=0 holds the bubble; `instr_d` stays NOP_INSTR.

## Timing
- Fetch-to-decode latency: 1 cycle.
  - The first rising edge with `rst`=0 produces `pc_d`=RESET_PC, `valid_d`=1, `instr_d`=`mem[RESET_PC]`.
- Steady state: 1 instruction per cycle; `pc_d` increments by 1 per cycle.
- Branch penalty:
  - The edge with `branch_taken` produces a 1-cycle bubble.
  - The following edge presents `pc_d`=target and `instr_d`=`mem[target]`.
- Stall:
  - Outputs are frozen for the entire stall, including `instr_d`, even though `imem_rdata` changes.
  - The first non-stall edge advances to `pc_d`+1.
- Reset mid-stall or mid-branch: reset state on the next edge, and the pending redirect is lost.
- `branch_taken` and `stall` together: the branch wins, `hold` clears, and the bubble is emitted.
- No combinational path from `stall`/`branch_*` to any output. `imem_addr` depends only on `pc_f`.

## Test plan
- Reset/stream:
  - Stimulus: `mem[0..3]`={32'h0080_0199, 32'hC000_0200, 32'h0C90_0000, 32'hC000_0330}; hold `rst` 2 cycles, then release.
  - Required: edges 1..4 give `pc_d`=0,1,2,3 with matching `instr_d`, `valid_d`=1; `fetch_count`=3 after edge 4.
- Stall hold:
  - Stimulus: `stall`=1 for 3 cycles while `pc_d`=2.
  - Required: `instr_d`=32'h0C90_0000, `pc_d`=2, `fetch_count` frozen; the release edge gives `pc_d`=3, `instr_d`=32'hC000_0330.
- Branch redirect:
  - Stimulus: `branch_taken`=1, `branch_target`=16 at `pc_d`=1.
  - Required: next cycle `valid_d`=0, `instr_d`=NOP_INSTR; following cycle `pc_d`=16, `instr_d`=`mem[16]`, `valid_d`=1.
- Branch during stall:
  - Stimulus: `stall`=1 and `branch_taken`=1 (target 25) on the same edge.
  - Required: bubble, then `pc_d`=25, `hold`=0; `fetch_count` not incremented on that edge.
- PC wrap:
  - Stimulus: `PC_W`=4, branch to 15.
  - Required: `pc_d` sequence 15, 0, 1.
- Reset mid-stall:
  - Stimulus: assert `rst` during a stall.
  - Required: next edge `valid_d`=0, `fetch_count`=0, `imem_addr`=RESET_PC.
